// File: rtl/div_iterative.sv
// Multi-cycle restoring divider: one trial subtraction per cycle, sign fixup in a final cycle.
// Quotient feeds LO, remainder feeds HI; control pulses start and stalls until done.
module div_iterative #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] dvd, dvd_n;
  logic [WIDTH-1:0] dsr, dsr_n;
  logic [WIDTH-1:0] prem, prem_n;
  logic [CW-1:0]    count, count_n;
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic             zero, zero_n;
  logic             busy_n, done_n, dbz_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;
  logic [WIDTH:0]   trial;
  logic             dvd_neg, dsr_neg;

  assign dvd_neg = SIGNED && dividend[WIDTH-1];
  assign dsr_neg = SIGNED && divisor[WIDTH-1];

  // Partial remainder < divisor, so WIDTH+1 bits hold the shifted value's trial difference.
  assign trial = {prem, dvd[WIDTH-1]} - {1'b0, dsr};

  always_comb begin
    state_n     = state;
    dvd_n       = dvd;
    dsr_n       = dsr;
    prem_n      = prem;
    count_n     = count;
    neg_q_n     = neg_q;
    neg_r_n     = neg_r;
    zero_n      = zero;
    busy_n      = busy;
    done_n      = 1'b0;
    dbz_n       = div_by_zero;
    quotient_n  = quotient;
    remainder_n = remainder;
    case (state)
      IDLE: begin
        if (start) begin
          dvd_n   = dvd_neg ? -dividend : dividend;
          dsr_n   = dsr_neg ? -divisor : divisor;
          neg_q_n = dvd_neg ^ dsr_neg;
          neg_r_n = dvd_neg;
          zero_n  = (divisor == '0);
          prem_n  = '0;
          count_n = '0;
          busy_n  = 1'b1;
          dbz_n   = 1'b0;
          state_n = (divisor == '0) ? FIXUP : RUN;
        end
      end
      RUN: begin
        // Quotient bits shift into the dividend register as dividend bits shift out.
        if (!trial[WIDTH]) begin
          prem_n = trial[WIDTH-1:0];
        end else begin
          prem_n = {prem[WIDTH-2:0], dvd[WIDTH-1]};
        end
        dvd_n   = {dvd[WIDTH-2:0], ~trial[WIDTH]};
        count_n = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          state_n = FIXUP;
        end
      end
      FIXUP: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
        if (zero) begin
          // Restoring the latched sign recovers the original dividend bit pattern.
          quotient_n  = '1;
          remainder_n = neg_r ? -dvd : dvd;
          dbz_n       = 1'b1;
        end else begin
          quotient_n  = neg_q ? -dvd : dvd;
          remainder_n = neg_r ? -prem : prem;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd         <= '0;
      dsr         <= '0;
      prem        <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      state       <= state_n;
      dvd         <= dvd_n;
      dsr         <= dsr_n;
      prem        <= prem_n;
      count       <= count_n;
      neg_q       <= neg_q_n;
      neg_r       <= neg_r_n;
      zero        <= zero_n;
      busy        <= busy_n;
      done        <= done_n;
      div_by_zero <= dbz_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
    end
  end

endmodule

// File: tb/tb_div_iterative.sv
// Bench for div_iterative: signed and unsigned instances driven in lockstep,
// checked against plain integer division.
module tb_div_iterative;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;

  logic         busy_s, done_s, dbz_s;
  logic [W-1:0] q_s, r_s;
  logic         busy_u, done_u, dbz_u;
  logic [W-1:0] q_u, r_u;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_iterative #(.WIDTH(W), .SIGNED(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy_s), .done(done_s), .quotient(q_s), .remainder(r_s), .div_by_zero(dbz_s)
  );

  div_iterative #(.WIDTH(W), .SIGNED(1'b0)) u_u (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy_u), .done(done_u), .quotient(q_u), .remainder(r_u), .div_by_zero(dbz_u)
  );

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit sgn);
    longint x, y;
    if (b == '0) return '1;
    x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    return W'(x / y);
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input bit sgn);
    longint x, y;
    if (b == '0) return a;
    x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    return W'(x % y);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy_s"}, W'(busy_s), '0);
    chk({tag, "_done_s"}, W'(done_s), '0);
    chk({tag, "_q_s"}, q_s, '0);
    chk({tag, "_r_s"}, r_s, '0);
    chk({tag, "_dbz_s"}, W'(dbz_s), '0);
    chk({tag, "_busy_u"}, W'(busy_u), '0);
    chk({tag, "_q_u"}, q_u, '0);
    chk({tag, "_r_u"}, r_u, '0);
  endtask

  // Called at a negedge; returns at the negedge after the start edge with operands scrambled.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    chk("busy_after_start_s", W'(busy_s), W'(1));
    chk("busy_after_start_u", W'(busy_u), W'(1));
  endtask

  task automatic await_done(input logic [W-1:0] a, input logic [W-1:0] b, input int start_lat);
    int lat = start_lat;
    int bcnt = start_lat;
    int exp_lat = (b == '0) ? 1 : int'(W) + 1;
    while (!done_s && lat < 200) begin
      if (busy_s) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("latency", W'(lat), W'(exp_lat));
    chk("busy_cycles", W'(bcnt), W'(exp_lat));
    chk("busy_at_done_s", W'(busy_s), '0);
    chk("done_u", W'(done_u), W'(1));
    chk("quot_s", q_s, ref_q(a, b, 1'b1));
    chk("rem_s", r_s, ref_r(a, b, 1'b1));
    chk("dbz_s", W'(dbz_s), W'(b == '0));
    chk("quot_u", q_u, ref_q(a, b, 1'b0));
    chk("rem_u", r_u, ref_r(a, b, 1'b0));
    chk("dbz_u", W'(dbz_u), W'(b == '0));
  endtask

  task automatic check_hold(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    chk("done_pulse_s", W'(done_s), '0);
    chk("hold_quot_s", q_s, ref_q(a, b, 1'b1));
    chk("hold_rem_u", r_u, ref_r(a, b, 1'b0));
  endtask

  initial begin
    logic [W-1:0] a, b;
    int saw_done;

    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(W'(555), W'(55));
    await_done(W'(555), W'(55), 0);
    check_hold(W'(555), W'(55));

    launch(W'(-555), W'(55));
    await_done(W'(-555), W'(55), 0);
    launch(W'(55), W'(555));
    await_done(W'(55), W'(555), 0);

    launch(W'(7), W'(0));
    await_done(W'(7), W'(0), 0);
    check_hold(W'(7), W'(0));
    launch(W'(100), W'(10));
    await_done(W'(100), W'(10), 0);

    launch(32'h8000_0000, 32'hFFFF_FFFF);
    await_done(32'h8000_0000, 32'hFFFF_FFFF, 0);
    launch(W'(-7), W'(0));
    await_done(W'(-7), W'(0), 0);

    // Second start mid-operation must be ignored.
    launch(W'(555), W'(55));
    repeat (9) @(negedge clk);
    start = 1'b1;
    dividend = W'(9);
    divisor = W'(3);
    @(negedge clk);
    start = 1'b0;
    await_done(W'(555), W'(55), 10);
    // Start on the done cycle is accepted.
    launch(W'(9), W'(3));
    await_done(W'(9), W'(3), 0);

    // Reset mid-division abandons the operation.
    @(negedge clk);
    launch(W'(1000), W'(7));
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_s || done_u) saw_done = 1;
    end
    chk("no_done_after_reset", W'(saw_done), '0);
    launch(W'(1000), W'(7));
    await_done(W'(1000), W'(7), 0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = W'($urandom_range(0, 20));
        1: b = W'(-int'($urandom_range(1, 20)));
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (i == 5) b = '0;
      @(negedge clk);
      launch(a, b);
      await_done(a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
